text_ram_arbiter: RTL and testbench
===================================

# text_ram_arbiter

Shares the single port of the text RAM between the display line fetcher and the parser's line-edit engine. Each requester gets one RAM access per grant. Returned read data is routed back to whichever requester issued the read. The display fetcher has fixed priority. An optional starvation guard bounds how long the editor can wait. The block sits between the parser (line edit, scroll and clear sequencing) and the text RAM instance, and owns every RAM control signal.

## Interface
Parameters:
- ADDR_W, 8: row address width.
- DATA_W, `TEXT_RAM_LINE_WIDTH`: one full text line.
- READ_LATENCY, 2: RAM cycles from registered address to valid `ram_rdata`; legal range 1..4.
- STARVE_MAX, 4: maximum consecutive display grants while the editor is pending; legal range 1..15.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request; held until `disp_gnt`.
- disp_addr  in  ADDR_W  row to read; stable while `disp_req`.
- disp_gnt  out  1  combinational accept pulse.
- disp_rvalid  out  1  read data valid, one cycle.
- disp_rdata  out  DATA_W  read line.
- ed_req  in  1  editor request; held until `ed_gnt`.
- ed_wren  in  1  1 = write, 0 = read.
- ed_addr  in  ADDR_W  target row.
- ed_wdata  in  DATA_W  write line.
- ed_gnt  out  1  combinational accept pulse.
- ed_rvalid  out  1  editor read data valid, one cycle.
- ed_rdata  out  DATA_W  read line.
- ram_addr  out  ADDR_W  registered.
- ram_wren  out  1  registered.
- ram_wdata  out  DATA_W  registered.
- ram_rdata  in  DATA_W  RAM read output.

## Operation
- At most one grant per cycle. `disp_gnt` and `ed_gnt` are never high together.
- Arbitration state: PRI_DISP (default) and PRI_EDIT (guard fired, only exists with `TEXT_ARB_STARVE_GUARD_EN`).
  - PRI_DISP: `disp_req` wins. `ed_req` is granted only when `disp_req` is low.
  - PRI_EDIT: `ed_req` wins. After the editor grant, the state returns to PRI_DISP.
- Starvation counter `starve_cnt` (4 bit):
  - Increments on each cycle with `disp_gnt` and `ed_req` both high.
  - Clears on `ed_gnt` or when `ed_req` is low.
  - Reaching STARVE_MAX moves the state to PRI_EDIT for the next cycle.
- On a granted request, the registers capture address, `wren` and write data for the next cycle: `ram_wren` = `ed_wren` for an editor grant, 0 for a display grant.
- A cycle with no grant drives `ram_wren` = 0. `ram_addr` and `ram_wdata` hold their previous values.
- Read return tracking:
  - A tag pipeline of depth 1+READ_LATENCY carries {valid, owner} for each read grant. Writes carry valid = 0.
  - At the pipeline output: `*_rvalid` goes high for the tagged owner, and `*_rdata` = `ram_rdata`, passed combinationally to both outputs.
- Ordering: all accesses reach the RAM in grant order. An editor read-modify-write on one row therefore sees its own earlier write. A display read granted after an editor write returns the new data.
- Requesters must hold `req` and payload until their grant. A request dropped before its grant is simply never serviced; the arbiter keeps no record of it.

## Timing
- Reset (`rst_n` low, asynchronous) clears: `ram_wren`=0, `ram_addr`=0, `ram_wdata`=0, tag pipeline, `starve_cnt`=0, state PRI_DISP. Both `rvalid` outputs = 0.
- Reset mid-read discards outstanding tags; no `rvalid` appears after `rst_n` rises.
- Grant cycle T: `gnt` high in T, combinational from `req` and state.
- The RAM sees the access in T+1.
- Read data with `rvalid` arrives in T+1+READ_LATENCY, which is 3 cycles with the default latency.
- Throughput: one access per cycle, back-to-back reads/writes from either requester allowed.
- Simultaneous `disp_req` and `ed_req` in PRI_DISP: display granted, `starve_cnt`+1.
- `starve_cnt` compare is against STARVE_MAX. Counter width is 4 bits, and there is no wrap because it clears on reaching PRI_EDIT.

## Configuration
- `TEXT_ARB_STARVE_GUARD_EN` defined:
  - `starve_cnt` and the PRI_EDIT state are built.
  - Editor wait is bounded to STARVE_MAX+1 cycles under continuous display requests.
- Not defined:
  - Pure fixed display priority; `starve_cnt` and PRI_EDIT are absent.
  - The editor is served only in cycles where `disp_req` is low.

## Test plan
- Reset: hold `rst_n`=0 with both requests high → no grants, `ram_wren`=0, both `rvalid`=0.
- Display read latency: single display read of address 0x05, RAM row 5 = pattern A → `disp_gnt` in T, `ram_addr`=0x05 in T+1, `disp_rvalid`=1 with A in T+3, `ed_rvalid`=0 throughout.
- Read-after-write ordering: editor write 0x10 = B in T, then editor read 0x10 in T+1 → `ram_wren` 1 then 0, `ed_rvalid` in T+4 with B.
- Simultaneous requests, guard enabled, STARVE_MAX=4: continuous `disp_req` plus `ed_req` → display granted 4 cycles, editor granted on the 5th, display resumes on the 6th. With the macro undefined: editor never granted until `disp_req` drops.
- Mixed pipeline: alternate display/editor reads every cycle for 8 cycles → each `rvalid` lands on the correct owner in issue order, with no cycle where both are high.
- Reset mid-flight: assert `rst_n`=0 one cycle after a read grant → no `rvalid` after release, first new grant behaves like the display-read-latency case.

Source files
------------

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: display fetcher (fixed priority) vs line-edit engine.
// Optional starvation guard for the editor is built when TEXT_ARB_STARVE_GUARD_EN is defined.

`ifndef TEXT_RAM_LINE_WIDTH
`define TEXT_RAM_LINE_WIDTH 128
`endif

module text_ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = `TEXT_RAM_LINE_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              ed_req,
  input  logic              ed_wren,
  input  logic [ADDR_W-1:0] ed_addr,
  input  logic [DATA_W-1:0] ed_wdata,
  output logic              ed_gnt,
  output logic              ed_rvalid,
  output logic [DATA_W-1:0] ed_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dbg_state
);

  localparam int DEPTH = 1 + READ_LATENCY;

  typedef enum logic {
    PRI_DISP = 1'b0,
    PRI_EDIT = 1'b1
  } arb_state_t;

  arb_state_t state;
  logic       edit_first;

  // Handshake: a requester holds req and payload; gnt is a same-cycle accept pulse,
  // and the RAM sees the accepted access on the following cycle.
  assign disp_gnt = rst_n & disp_req & ~edit_first;
  assign ed_gnt   = rst_n & ed_req & (edit_first | ~disp_req);

`ifdef TEXT_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRI_DISP;
      starve_cnt <= 4'd0;
    end else if (ed_gnt || !ed_req) begin
      state      <= PRI_DISP;
      starve_cnt <= 4'd0;
    end else if (disp_gnt) begin
      // Counter clears when priority flips, so it never wraps.
      if (starve_cnt + 4'd1 >= 4'(STARVE_MAX)) begin
        state      <= PRI_EDIT;
        starve_cnt <= 4'd0;
      end else begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign edit_first = (state == PRI_EDIT) & ed_req;
`else
  assign state      = PRI_DISP;
  assign edit_first = 1'b0;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wren  <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_wren <= ed_gnt & ed_wren;
      if (disp_gnt) begin
        ram_addr <= disp_addr;
      end else if (ed_gnt) begin
        ram_addr  <= ed_addr;
        ram_wdata <= ed_wdata;
      end
    end
  end

  // Read tags: bit 0 enters with the grant, the top bit lines up with ram_rdata.
  logic [DEPTH-1:0] tag_v;
  logic [DEPTH-1:0] tag_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= {tag_v[DEPTH-2:0], disp_gnt | (ed_gnt & ~ed_wren)};
      tag_o <= {tag_o[DEPTH-2:0], ed_gnt};
    end
  end

  assign disp_rvalid = tag_v[DEPTH-1] & ~tag_o[DEPTH-1];
  assign ed_rvalid   = tag_v[DEPTH-1] &  tag_o[DEPTH-1];
  assign disp_rdata  = ram_rdata;
  assign ed_rdata    = ram_rdata;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: behavioural RAM, shadow-memory reference model and
// a read-return scoreboard; follows TEXT_ARB_STARVE_GUARD_EN if defined.

module tb_text_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 128;
  localparam int RL = 2;
  localparam int SMAX = 4;
`ifdef TEXT_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_req, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          ed_req, ed_wren, ed_gnt, ed_rvalid;
  logic [AW-1:0] ed_addr;
  logic [DW-1:0] ed_wdata, ed_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  text_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ed_req(ed_req), .ed_wren(ed_wren), .ed_addr(ed_addr), .ed_wdata(ed_wdata),
    .ed_gnt(ed_gnt), .ed_rvalid(ed_rvalid), .ed_rdata(ed_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural RAM (READ_LATENCY cycles addr -> data) ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RL-1];

  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = rd_pipe[RL-1];

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          due;
    bit          owner;   // 1 = editor
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            m_wait;
  bit            m_edit;
  logic          x_wren;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;

  always @(negedge clk) begin
    exp_t r;
    bit   e_d, e_e, e_dg, e_eg, edit_first;
    logic [DW-1:0] e_data;
    if (!rst_n) begin
      m_wait = 0; m_edit = 0;
      x_wren = 1'b0; x_addr = '0; x_wdata = '0;
      exp_q.delete();
    end else begin
      checks++;
      if (ram_wren !== x_wren) begin
        errors++; $display("FAIL sb_ram_wren cyc %0d got %b exp %b", cyc, ram_wren, x_wren);
      end
      checks++;
      if (ram_addr !== x_addr) begin
        errors++; $display("FAIL sb_ram_addr cyc %0d got %h exp %h", cyc, ram_addr, x_addr);
      end
      checks++;
      if (ram_wdata !== x_wdata) begin
        errors++; $display("FAIL sb_ram_wdata cyc %0d got %h exp %h", cyc, ram_wdata, x_wdata);
      end
      e_d = 0; e_e = 0; e_data = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        e_d = !r.owner; e_e = r.owner; e_data = r.data;
      end
      checks++;
      if ({disp_rvalid, ed_rvalid} !== {e_d, e_e}) begin
        errors++; $display("FAIL sb_rvalid cyc %0d got d%b e%b exp d%b e%b",
                           cyc, disp_rvalid, ed_rvalid, e_d, e_e);
      end
      if (e_d) begin
        checks++;
        if (disp_rdata !== e_data) begin
          errors++; $display("FAIL sb_disp_rdata cyc %0d got %h exp %h", cyc, disp_rdata, e_data);
        end
      end
      if (e_e) begin
        checks++;
        if (ed_rdata !== e_data) begin
          errors++; $display("FAIL sb_ed_rdata cyc %0d got %h exp %h", cyc, ed_rdata, e_data);
        end
      end
      // display wins unless the editor has been passed over STARVE_MAX times
      edit_first = GUARD && m_edit && ed_req;
      e_dg = disp_req && !edit_first;
      e_eg = ed_req && !e_dg;
      checks++;
      if ({disp_gnt, ed_gnt} !== {e_dg, e_eg}) begin
        errors++; $display("FAIL sb_gnt cyc %0d got d%b e%b exp d%b e%b",
                           cyc, disp_gnt, ed_gnt, e_dg, e_eg);
      end
      x_wren = 1'b0;
      if (e_dg) begin
        x_addr = disp_addr;
        exp_q.push_back('{cyc + 1 + RL, 1'b0, shadow[disp_addr]});
      end else if (e_eg) begin
        x_addr  = ed_addr;
        x_wdata = ed_wdata;
        x_wren  = ed_wren;
        if (ed_wren) shadow[ed_addr] = ed_wdata;
        else exp_q.push_back('{cyc + 1 + RL, 1'b1, shadow[ed_addr]});
      end
      if (!ed_req || e_eg) begin
        m_wait = 0; m_edit = 0;
      end else if (e_dg) begin
        m_wait++;
        if (m_wait >= SMAX) begin m_edit = 1; m_wait = 0; end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = '0;
    for (int i = 0; i < DW; i += 32) d = (d << 32) | DW'($urandom());
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; disp_req = 1'b1; ed_req = 1'b1; ed_wren = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({disp_gnt, ed_gnt} !== 2'b00) begin
        errors++; $display("FAIL reset_gnt got %b%b exp 00", disp_gnt, ed_gnt);
      end
      checks++;
      if ({ram_wren, disp_rvalid, ed_rvalid} !== 3'b000) begin
        errors++; $display("FAIL reset_outs got %b%b%b exp 000", ram_wren, disp_rvalid, ed_rvalid);
      end
      checks++;
      if (ram_addr !== '0) begin
        errors++; $display("FAIL reset_addr got %h exp 00", ram_addr);
      end
    end
    next_cycle();
    disp_req = 1'b0; ed_req = 1'b0; ed_wren = 1'b0;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fill();
    for (int a = 0; a < (1 << AW); a++) begin
      ed_req = 1'b1; ed_wren = 1'b1; ed_addr = AW'(a); ed_wdata = rand_data();
      @(negedge clk);
      checks++;
      if (ed_gnt !== 1'b1) begin
        errors++; $display("FAIL fill_gnt row %0d got %b exp 1", a, ed_gnt);
      end
      next_cycle();
    end
    ed_req = 1'b0; ed_wren = 1'b0;
    next_cycle();
  endtask

  task automatic test_disp_latency(input logic [AW-1:0] a);
    logic [DW-1:0] exp_data;
    exp_data = shadow[a];
    disp_req = 1'b1; disp_addr = a;
    @(negedge clk);
    checks++;
    if ({disp_gnt, ed_gnt} !== 2'b10) begin
      errors++; $display("FAIL lat_gnt got d%b e%b exp d1 e0", disp_gnt, ed_gnt);
    end
    next_cycle();
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_addr !== a || ram_wren !== 1'b0) begin
      errors++; $display("FAIL lat_ram got addr %h wren %b exp addr %h wren 0", ram_addr, ram_wren, a);
    end
    @(negedge clk);
    checks++;
    if (disp_rvalid !== 1'b0) begin
      errors++; $display("FAIL lat_early got %b exp 0", disp_rvalid);
    end
    @(negedge clk);
    checks++;
    if (disp_rvalid !== 1'b1 || ed_rvalid !== 1'b0 || disp_rdata !== exp_data) begin
      errors++; $display("FAIL lat_data got v%b e%b %h exp v1 e0 %h", disp_rvalid, ed_rvalid, disp_rdata, exp_data);
    end
    next_cycle();
  endtask

  task automatic test_raw();
    logic [DW-1:0] b;
    b = rand_data();
    ed_req = 1'b1; ed_wren = 1'b1; ed_addr = 8'h10; ed_wdata = b;
    @(negedge clk);
    checks++;
    if (ed_gnt !== 1'b1) begin
      errors++; $display("FAIL raw_wr_gnt got %b exp 1", ed_gnt);
    end
    next_cycle();
    ed_wren = 1'b0; ed_wdata = rand_data();
    @(negedge clk);
    checks++;
    if (ed_gnt !== 1'b1 || ram_wren !== 1'b1) begin
      errors++; $display("FAIL raw_rd_gnt got gnt %b wren %b exp 1 1", ed_gnt, ram_wren);
    end
    next_cycle();
    ed_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_wren !== 1'b0) begin
      errors++; $display("FAIL raw_wren_low got %b exp 0", ram_wren);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ed_rvalid !== 1'b1 || ed_rdata !== b) begin
      errors++; $display("FAIL raw_data got v%b %h exp v1 %h", ed_rvalid, ed_rdata, b);
    end
    next_cycle();
  endtask

  task automatic test_starve();
    bit exp_eg;
    ed_req = 1'b1; ed_wren = 1'b0; ed_addr = AW'($urandom_range(0, 255));
    disp_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      disp_addr = AW'($urandom_range(0, 255));
      exp_eg = GUARD && (i == SMAX);
      @(negedge clk);
      checks++;
      if ({disp_gnt, ed_gnt} !== {!exp_eg, exp_eg}) begin
        errors++; $display("FAIL starve_gnt step %0d got d%b e%b exp d%b e%b",
                           i, disp_gnt, ed_gnt, !exp_eg, exp_eg);
      end
      checks++;
      if (dbg_state !== exp_eg) begin
        errors++; $display("FAIL starve_state step %0d got %b exp %b", i, dbg_state, exp_eg);
      end
      next_cycle();
      if (exp_eg) ed_req = 1'b0;
    end
    disp_req = 1'b0;
    if (ed_req) begin
      @(negedge clk);
      checks++;
      if (ed_gnt !== 1'b1) begin
        errors++; $display("FAIL starve_release got %b exp 1", ed_gnt);
      end
      next_cycle();
      ed_req = 1'b0;
    end
    repeat (RL + 2) next_cycle();
  endtask

  task automatic test_mixed();
    int nd = 0, ne = 0, nb = 0;
    ed_wren = 1'b0;
    for (int i = 0; i < 8 + RL + 3; i++) begin
      if (i < 8) begin
        disp_req = (i % 2 == 0); ed_req = (i % 2 == 1);
        disp_addr = AW'($urandom_range(0, 255)); ed_addr = AW'($urandom_range(0, 255));
      end else begin
        disp_req = 1'b0; ed_req = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if ({disp_gnt, ed_gnt} !== {disp_req, ed_req}) begin
          errors++; $display("FAIL mixed_gnt step %0d got d%b e%b exp d%b e%b",
                             i, disp_gnt, ed_gnt, disp_req, ed_req);
        end
      end
      nd += int'(disp_rvalid); ne += int'(ed_rvalid); nb += int'(disp_rvalid & ed_rvalid);
      next_cycle();
    end
    checks++;
    if (nd != 4 || ne != 4 || nb != 0) begin
      errors++; $display("FAIL mixed_counts got d%0d e%0d both%0d exp d4 e4 both0", nd, ne, nb);
    end
  endtask

  task automatic test_reset_midflight();
    disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 255));
    @(negedge clk);
    checks++;
    if (disp_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_gnt got %b exp 1", disp_gnt);
    end
    next_cycle();
    disp_req = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({disp_rvalid, ed_rvalid} !== 2'b00) begin
        errors++; $display("FAIL mid_stale step %0d got d%b e%b exp 00", i, disp_rvalid, ed_rvalid);
      end
      next_cycle();
    end
    test_disp_latency(AW'($urandom_range(0, 255)));
  endtask

  task automatic test_random();
    bit dg, eg;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dg = disp_gnt; eg = ed_gnt;
      next_cycle();
      if (!disp_req || dg) begin
        disp_req  = ($urandom_range(0, 99) < 60);
        disp_addr = AW'($urandom_range(0, 15));
      end
      if (!ed_req || eg) begin
        ed_req   = ($urandom_range(0, 99) < 50);
        ed_wren  = $urandom_range(0, 1) == 1;
        ed_addr  = AW'($urandom_range(0, 15));
        ed_wdata = rand_data();
      end
    end
    @(negedge clk);
    next_cycle();
    disp_req = 1'b0; ed_req = 1'b0;
    repeat (RL + 4) next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    ed_req = 1'b0; ed_wren = 1'b0; ed_addr = '0; ed_wdata = '0;
    #1;
    test_reset();
    test_fill();
    test_disp_latency(8'h05);
    test_raw();
    test_starve();
    test_mixed();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
